// File: rtl/seg_pkg.sv
// Shared constants for the BCD seven-segment scanner: nibble fields, segment patterns, digit index.
package seg_pkg;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned AN_W     = 3;
  localparam int unsigned HUND_LSB = 8;
  localparam int unsigned TENS_LSB = 4;
  localparam int unsigned UNIT_LSB = 0;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUND  = 2'd2
  } dig_idx_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-BCD nibbles show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg_n_c
);

  always_comb begin
    o_seg_n_c = SEG_DASH;
    case (i_nib)
      4'd0:    o_seg_n_c = SEG_0;
      4'd1:    o_seg_n_c = SEG_1;
      4'd2:    o_seg_n_c = SEG_2;
      4'd3:    o_seg_n_c = SEG_3;
      4'd4:    o_seg_n_c = SEG_4;
      4'd5:    o_seg_n_c = SEG_5;
      4'd6:    o_seg_n_c = SEG_6;
      4'd7:    o_seg_n_c = SEG_7;
      4'd8:    o_seg_n_c = SEG_8;
      4'd9:    o_seg_n_c = SEG_9;
      default: o_seg_n_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Three-digit multiplexed seven-segment driver with per-slot anti-ghost blanking and frame pulse.
// Build option: LEADING_ZERO_BLANK_EN suppresses leading-zero hundreds/tens digits.
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             load,
  output logic [SEG_W-1:0] seg_n,
  output logic [AN_W-1:0]  an_n,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  dig_idx_e         r_idx;
  logic [BCD_W-1:0] r_hold;

  logic             w_cnt_wrap;
  logic [NIB_W-1:0] w_nib;
  logic [SEG_W-1:0] w_seg_n;
  logic [AN_W-1:0]  w_an_sel_n;
  logic             w_dig_blank;
  logic             w_lit;

  assign w_cnt_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));

  // Hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (load) begin
      r_hold <= bcd_in;
    end
  end

  // Slot counter and digit index; an illegal index recovers to units
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= DIG_UNITS;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
      case (r_idx)
        DIG_UNITS: r_idx <= w_cnt_wrap ? DIG_TENS  : DIG_UNITS;
        DIG_TENS:  r_idx <= w_cnt_wrap ? DIG_HUND  : DIG_TENS;
        DIG_HUND:  r_idx <= w_cnt_wrap ? DIG_UNITS : DIG_HUND;
        default:   r_idx <= DIG_UNITS;
      endcase
    end
  end

  always_comb begin
    w_nib      = r_hold[UNIT_LSB +: NIB_W];
    w_an_sel_n = 3'b111;
    case (r_idx)
      DIG_UNITS: begin w_nib = r_hold[UNIT_LSB +: NIB_W]; w_an_sel_n = 3'b110; end
      DIG_TENS:  begin w_nib = r_hold[TENS_LSB +: NIB_W]; w_an_sel_n = 3'b101; end
      DIG_HUND:  begin w_nib = r_hold[HUND_LSB +: NIB_W]; w_an_sel_n = 3'b011; end
      default:   begin w_nib = r_hold[UNIT_LSB +: NIB_W]; w_an_sel_n = 3'b111; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Tens is only a leading zero when hundreds is also zero
  assign w_dig_blank = ((r_idx == DIG_HUND) && (r_hold[HUND_LSB +: NIB_W] == '0)) ||
                       ((r_idx == DIG_TENS) && (r_hold[TENS_LSB +: 2*NIB_W] == '0));
`else
  assign w_dig_blank = 1'b0;
`endif

  assign w_lit = (r_cnt >= CNT_W'(BLANK_CYCLES)) && !w_dig_blank && (w_an_sel_n != 3'b111);

  bcd_to_seg u_bcd_to_seg (
    .i_nib     (w_nib),
    .o_seg_n_c (w_seg_n)
  );

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_BLANK;
      an_n       <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= w_lit ? w_seg_n : SEG_BLANK;
      an_n       <= w_lit ? w_an_sel_n : 3'b111;
      frame_done <= w_cnt_wrap && (r_idx == DIG_HUND);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomized self-checking bench for bcd_seg_scanner against a frame-position reference model.
module tb_bcd_seg_scanner;

  localparam int unsigned CLK_DIV      = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned FRAME        = 3 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;
  logic        frame_done;

  int n_checks;
  int n_errors;
  int pos;
  logic [11:0] m_hold;

  bcd_seg_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (pos %0d hold %03h)", tag, got, exp, pos, m_hold);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected outputs after an edge, from frame position and held value before that edge
  task automatic expect_out(input int p, input logic [11:0] h,
                            output logic [6:0] e_seg, output logic [2:0] e_an,
                            output logic e_fd);
    int slot, c, d;
    bit lit;
    slot = p / CLK_DIV;
    c    = p % CLK_DIV;
    d    = (h >> (4 * slot)) & 15;
    lit  = (c >= BLANK_CYCLES);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2 && h / 256 == 0) lit = 0;
    if (slot == 1 && h / 16 == 0) lit = 0;
`endif
    e_seg = lit ? seg_of(d) : 7'h7F;
    e_an  = lit ? 3'(7 - (1 << slot)) : 3'b111;
    e_fd  = (p == FRAME - 1);
  endtask

  task automatic step(input logic ld, input logic [11:0] v);
    logic [6:0] e_seg;
    logic [2:0] e_an;
    logic       e_fd;
    @(negedge clk);
    load   = ld;
    bcd_in = v;
    @(posedge clk);
    expect_out(pos, m_hold, e_seg, e_an, e_fd);
    if (ld) m_hold = v;
    pos = (pos + 1) % FRAME;
    #1;
    chk("seg_n", 32'(seg_n), 32'(e_seg));
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(4095));
  endtask

  task automatic load_val(input logic [11:0] v);
    step(1'b1, v);
  endtask

  // Advance with no load until the next edge will see frame position p
  task automatic run_to(input int p);
    while (pos != p) step(1'b0, 12'h000);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, 32'(seg_n), 32'h7F);
    chk({tag, "_an"}, 32'(an_n), 32'h7);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    bcd_in   = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    pos    = 0;
    m_hold = 12'h000;

    idle(FRAME);
    load_val(12'h255);
    idle(2 * FRAME);
    load_val(12'h1A3);
    idle(FRAME + 5);
    load_val(12'h007);
    idle(FRAME);
    load_val(12'h000);
    idle(FRAME);
    load_val(12'h090);
    idle(FRAME);
    load_val(12'hFFF);
    idle(FRAME);

    // Load mid-slot 0: 0x123 then 0x129 at cnt 5
    run_to(0);
    load_val(12'h123);
    run_to(5);
    load_val(12'h129);
    idle(FRAME);

    // Load coinciding with the wrap into slot 0
    run_to(FRAME - 1);
    load_val(12'h468);
    idle(FRAME);

    // Load held high continuously
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 12'($urandom_range(4095)));

    // Randomized loads, mostly valid BCD
    for (int i = 0; i < 400; i++) begin
      logic [11:0] v;
      v = ($urandom_range(7) == 0) ? 12'($urandom_range(4095))
                                   : 12'($urandom_range(9) * 256 + $urandom_range(9) * 16 + $urandom_range(9));
      if ($urandom_range(5) == 0) v = v & 12'h00F;
      step($urandom_range(9) == 0, v);
    end

    // Asynchronous reset during slot 2
    run_to(2 * CLK_DIV + 3);
    load_val(12'h987);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n  = 1'b1;
    pos    = 0;
    m_hold = 12'h000;
    idle(2 * FRAME);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
